// File: rtl/arb_req_queue.sv
// arb_req_queue: upstream request stage for the two-client grant arbiter.
// Each client has an independent channel that queues transactions, counts granted beats and flags overflow/starvation.
module arb_req_channel #(
    parameter int DEPTH   = 4,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       gnt,
    output logic       req,
    output logic [3:0] cnt,
    output logic       full,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic       starve
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    localparam logic [3:0] DEPTH_C   = 4'(DEPTH);
    localparam logic [3:0] BURST_C   = 4'(BURST);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state, state_next;
    logic [3:0] beat, beat_next, cnt_next;
    logic [7:0] wait_cnt, wait_next;
    logic       granted, complete, inc;

    assign req  = (state == REQ) || (state == XFER);
    assign busy = (state == XFER);
    assign full = (cnt == DEPTH_C);

    // Grants outside REQ/XFER are ignored; a push at full is accepted only when a completion frees a slot.
    always_comb begin
        granted  = ((state == REQ) || (state == XFER)) && gnt;
        complete = granted && ((beat + 4'd1) == BURST_C);
        inc      = push && (!full || complete);
        cnt_next = cnt + {3'd0, inc} - {3'd0, complete};

        state_next = state;
        unique case (state)
            IDLE: if (cnt_next != 4'd0) state_next = REQ;
            REQ: begin
                if (complete)  state_next = GAP;
                else if (gnt)  state_next = XFER;
            end
            XFER: begin
                if (complete)  state_next = GAP;
                else if (!gnt) state_next = REQ;
            end
            GAP:     state_next = (cnt != 4'd0) ? REQ : IDLE;
            default: state_next = IDLE;
        endcase

        beat_next = beat;
        if (state_next == GAP)
            beat_next = 4'd0;
        else if (granted)
            beat_next = beat + 4'd1;

        // Wait counter only runs while requesting without a grant, and saturates.
        wait_next = wait_cnt;
        if ((state_next == XFER) || (state_next == GAP))
            wait_next = 8'd0;
        else if ((state == REQ) && !gnt && (wait_cnt != 8'hFF))
            wait_next = wait_cnt + 8'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat     <= 4'd0;
            wait_cnt <= 8'd0;
            cnt      <= 4'd0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            starve   <= 1'b0;
        end else begin
            state    <= state_next;
            beat     <= beat_next;
            wait_cnt <= wait_next;
            cnt      <= cnt_next;
            done     <= complete;
            if (push && full && !complete)
                ovf <= 1'b1;
            if (wait_next == TIMEOUT_C)
                starve <= 1'b1;
        end
    end
endmodule

module arb_req_queue #(
    parameter int DEPTH   = 4,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_0,
    input  logic       push_1,
    input  logic       gnt_0,
    input  logic       gnt_1,
    output logic       req_0,
    output logic       req_1,
    output logic [3:0] cnt_0,
    output logic [3:0] cnt_1,
    output logic       full_0,
    output logic       full_1,
    output logic       busy_0,
    output logic       busy_1,
    output logic       done_0,
    output logic       done_1,
    output logic       ovf_0,
    output logic       ovf_1,
    output logic       starve_0,
    output logic       starve_1
);
    arb_req_channel #(.DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) u_ch0 (
        .clock  (clock),
        .reset  (reset),
        .push   (push_0),
        .gnt    (gnt_0),
        .req    (req_0),
        .cnt    (cnt_0),
        .full   (full_0),
        .busy   (busy_0),
        .done   (done_0),
        .ovf    (ovf_0),
        .starve (starve_0)
    );

    arb_req_channel #(.DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) u_ch1 (
        .clock  (clock),
        .reset  (reset),
        .push   (push_1),
        .gnt    (gnt_1),
        .req    (req_1),
        .cnt    (cnt_1),
        .full   (full_1),
        .busy   (busy_1),
        .done   (done_1),
        .ovf    (ovf_1),
        .starve (starve_1)
    );
endmodule

// File: tb/tb_arb_req_queue.sv
// Testbench for arb_req_queue: directed stimulus with a completion scoreboard per channel.
module tb_arb_req_queue;
    logic       clock = 1'b0;
    logic       reset;
    logic       push_0, push_1, gnt_0, gnt_1;
    logic       req_0, req_1, full_0, full_1, busy_0, busy_1;
    logic       done_0, done_1, ovf_0, ovf_1, starve_0, starve_1;
    logic [3:0] cnt_0, cnt_1;

    typedef struct {
        logic [3:0] cnt;
        logic       req_after;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks     = 0;
    int   failures   = 0;
    int   done_count0 = 0;
    int   done_count1 = 0;
    logic pend0 = 1'b0, pend1 = 1'b0;
    logic exp_req0 = 1'b0, exp_req1 = 1'b0;

    arb_req_queue #(.DEPTH(4), .BURST(4), .TIMEOUT(15)) dut (
        .clock    (clock),
        .reset    (reset),
        .push_0   (push_0),
        .push_1   (push_1),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .req_0    (req_0),
        .req_1    (req_1),
        .cnt_0    (cnt_0),
        .cnt_1    (cnt_1),
        .full_0   (full_0),
        .full_1   (full_1),
        .busy_0   (busy_0),
        .busy_1   (busy_1),
        .done_0   (done_0),
        .done_1   (done_1),
        .ovf_0    (ovf_0),
        .ovf_1    (ovf_1),
        .starve_0 (starve_0),
        .starve_1 (starve_1)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic p0, input logic p1, input logic g0, input logic g1);
        push_0 = p0;
        push_1 = p1;
        gnt_0  = g0;
        gnt_1  = g1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: each done pulse pops an expected completion and checks the GAP release and what follows it.
    always @(negedge clock) begin
        if (done_0) begin
            done_count0++;
            if (sb0.size() == 0) begin
                checkOutput("ch0_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb0.pop_front();
                checkOutput("ch0_done_cnt", int'(cnt_0), int'(e.cnt));
                checkOutput("ch0_done_req_gap", int'(req_0), 0);
                pend0    = 1'b1;
                exp_req0 = e.req_after;
            end
        end else if (pend0) begin
            checkOutput("ch0_req_after_gap", int'(req_0), int'(exp_req0));
            pend0 = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (done_1) begin
            done_count1++;
            if (sb1.size() == 0) begin
                checkOutput("ch1_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                checkOutput("ch1_done_cnt", int'(cnt_1), int'(e.cnt));
                checkOutput("ch1_done_req_gap", int'(req_1), 0);
                pend1    = 1'b1;
                exp_req1 = e.req_after;
            end
        end else if (pend1) begin
            checkOutput("ch1_req_after_gap", int'(req_1), int'(exp_req1));
            pend1 = 1'b0;
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        repeat (2) tick();
        checkOutput("rst_req_0", int'(req_0), 0);
        checkOutput("rst_req_1", int'(req_1), 0);
        checkOutput("rst_cnt_0", int'(cnt_0), 0);
        checkOutput("rst_full_1", int'(full_1), 0);
        checkOutput("rst_ovf_0", int'(ovf_0), 0);
        checkOutput("rst_starve_1", int'(starve_1), 0);
        reset = 1'b1;

        // Single transaction with grant held high.
        sb0.push_back('{4'd0, 1'b0});
        applyStimulus(1, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        checkOutput("t1_cnt", int'(cnt_0), 1);
        checkOutput("t1_req", int'(req_0), 1);
        checkOutput("t1_busy_req", int'(busy_0), 0);
        tick();
        checkOutput("t1_busy_xfer", int'(busy_0), 1);
        repeat (3) tick();
        checkOutput("t1_done", int'(done_0), 1);
        tick();
        checkOutput("t1_done_single", int'(done_0), 0);
        checkOutput("t1_idle_req", int'(req_0), 0);
        checkOutput("t1_idle_cnt", int'(cnt_0), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_done_count", done_count0, 1);

        // Back-to-back and overflow on channel 1.
        applyStimulus(0, 1, 0, 0);
        repeat (5) tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_cnt", int'(cnt_1), 4);
        checkOutput("t2_full", int'(full_1), 1);
        checkOutput("t2_ovf", int'(ovf_1), 1);
        checkOutput("t2_req", int'(req_1), 1);
        sb1.push_back('{4'd3, 1'b1});
        sb1.push_back('{4'd2, 1'b1});
        sb1.push_back('{4'd1, 1'b1});
        sb1.push_back('{4'd0, 1'b0});
        applyStimulus(0, 0, 0, 1);
        repeat (21) tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_done_count", done_count1, 4);
        checkOutput("t2_end_cnt", int'(cnt_1), 0);
        checkOutput("t2_end_req", int'(req_1), 0);
        checkOutput("t2_no_starve", int'(starve_1), 0);

        // Preemption: two beats, three ungranted cycles, then the remaining two beats.
        applyStimulus(1, 0, 0, 0);
        tick();
        sb0.push_back('{4'd0, 1'b0});
        applyStimulus(0, 0, 1, 0);
        repeat (2) tick();
        checkOutput("t3_busy", int'(busy_0), 1);
        applyStimulus(0, 0, 0, 0);
        tick();
        checkOutput("t3_preempt_busy", int'(busy_0), 0);
        checkOutput("t3_preempt_req", int'(req_0), 1);
        repeat (2) tick();
        checkOutput("t3_still_req", int'(req_0), 1);
        checkOutput("t3_no_early_done", done_count0, 1);
        applyStimulus(0, 0, 1, 0);
        tick();
        checkOutput("t3_not_done_3", int'(done_0), 0);
        tick();
        checkOutput("t3_done", int'(done_0), 1);
        applyStimulus(0, 0, 0, 0);
        tick();
        checkOutput("t3_idle_req", int'(req_0), 0);

        // Push on the completion edge while full.
        applyStimulus(1, 0, 0, 0);
        repeat (4) tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_cnt_full", int'(cnt_0), 4);
        checkOutput("t4_full", int'(full_0), 1);
        sb0.push_back('{4'd4, 1'b1});
        sb0.push_back('{4'd3, 1'b1});
        sb0.push_back('{4'd2, 1'b1});
        sb0.push_back('{4'd1, 1'b1});
        sb0.push_back('{4'd0, 1'b0});
        applyStimulus(0, 0, 1, 0);
        repeat (3) tick();
        applyStimulus(1, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        checkOutput("t4_done", int'(done_0), 1);
        checkOutput("t4_cnt_kept", int'(cnt_0), 4);
        checkOutput("t4_no_ovf", int'(ovf_0), 0);
        repeat (21) tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_end_cnt", int'(cnt_0), 0);
        checkOutput("t4_done_count", done_count0, 7);
        checkOutput("t4_ovf_end", int'(ovf_0), 0);
        checkOutput("t4_no_starve", int'(starve_0), 0);

        // Starvation on channel 1.
        applyStimulus(0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0);
        repeat (14) tick();
        checkOutput("t5_starve_early", int'(starve_1), 0);
        tick();
        checkOutput("t5_starve_set", int'(starve_1), 1);
        sb1.push_back('{4'd0, 1'b0});
        applyStimulus(0, 0, 0, 1);
        repeat (4) tick();
        checkOutput("t5_done", int'(done_1), 1);
        applyStimulus(0, 0, 0, 0);
        repeat (2) tick();
        checkOutput("t5_starve_sticky", int'(starve_1), 1);
        checkOutput("t5_ovf_sticky", int'(ovf_1), 1);

        // Reset during the second beat of a transfer with three pending.
        applyStimulus(1, 0, 0, 0);
        repeat (3) tick();
        applyStimulus(0, 0, 1, 0);
        checkOutput("t6_cnt", int'(cnt_0), 3);
        tick();
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_rst_req", int'(req_0), 0);
        checkOutput("t6_rst_cnt", int'(cnt_0), 0);
        checkOutput("t6_rst_busy", int'(busy_0), 0);
        checkOutput("t6_rst_starve_1", int'(starve_1), 0);
        checkOutput("t6_rst_ovf_1", int'(ovf_1), 0);
        applyStimulus(0, 0, 0, 0);
        repeat (2) tick();
        checkOutput("t6_rst_done", int'(done_0), 0);
        reset = 1'b1;
        sb0.push_back('{4'd0, 1'b0});
        applyStimulus(1, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 1, 0);
        checkOutput("t6_cnt_after", int'(cnt_0), 1);
        repeat (4) tick();
        checkOutput("t6_done", int'(done_0), 1);
        applyStimulus(0, 0, 0, 0);
        repeat (2) tick();

        checkOutput("final_done_count0", done_count0, 8);
        checkOutput("final_done_count1", done_count1, 5);
        checkOutput("final_sb0_empty", sb0.size(), 0);
        checkOutput("final_sb1_empty", sb1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
